// File: rtl/qqspi_arbiter.sv
// Two-port arbiter sharing one qqspi controller between an instruction-fetch port and a data port.
// Latency: m_valid one cycle after request is sampled in IDLE; ready pulse one cycle after m_ready; one RELEASE cycle minimum.
// Backpressure: requests are held off until IDLE; RELEASE waits for m_ready to drop before accepting the next request.
module qqspi_arbiter #(
    parameter logic ROUND_ROBIN = 1'b1,
    parameter logic PRIO_PORT   = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s0_valid,
    input  logic [22:0] s0_addr,
    input  logic [31:0] s0_wdata,
    input  logic [3:0]  s0_wstrb,
    output logic        s0_ready,
    output logic [31:0] s0_rdata,
    input  logic        s1_valid,
    input  logic [22:0] s1_addr,
    input  logic [31:0] s1_wdata,
    input  logic [3:0]  s1_wstrb,
    output logic        s1_ready,
    output logic [31:0] s1_rdata,
    output logic        m_valid,
    output logic [22:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    state_t      state_q;
    logic        last_grant_q;
    logic        grant_q;
    logic        m_valid_q;
    logic        busy_q;
    logic        s0_ready_q;
    logic        s1_ready_q;
    logic [22:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic [3:0]  m_wstrb_q;
    logic [31:0] s0_rdata_q;
    logic [31:0] s1_rdata_q;
    logic        grant_d;

    // Under contention the round-robin pointer picks the port that did not win last.
    always_comb begin
        grant_d = s1_valid;
        if (s0_valid && s1_valid) begin
            grant_d = ROUND_ROBIN ? ~last_grant_q : PRIO_PORT;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= ~PRIO_PORT;
            grant_q      <= 1'b0;
            m_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            s0_ready_q   <= 1'b0;
            s1_ready_q   <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
            s0_rdata_q   <= '0;
            s1_rdata_q   <= '0;
        end else begin
            s0_ready_q <= 1'b0;
            s1_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s0_valid || s1_valid) begin
                        grant_q   <= grant_d;
                        m_addr_q  <= grant_d ? s1_addr  : s0_addr;
                        m_wdata_q <= grant_d ? s1_wdata : s0_wdata;
                        m_wstrb_q <= grant_d ? s1_wstrb : s0_wstrb;
                        m_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        if (grant_q) begin
                            s1_rdata_q <= m_rdata;
                            s1_ready_q <= 1'b1;
                        end else begin
                            s0_rdata_q <= m_rdata;
                            s0_ready_q <= 1'b1;
                        end
                        m_valid_q    <= 1'b0;
                        last_grant_q <= grant_q;
                        state_q      <= RELEASE;
                    end
                end
                RELEASE: begin
                    // The controller holds ready until it sees valid low; let it return to its start state.
                    if (!m_ready) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_valid  = m_valid_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_wstrb  = m_wstrb_q;
    assign s0_ready = s0_ready_q;
    assign s1_ready = s1_ready_q;
    assign s0_rdata = s0_rdata_q;
    assign s1_rdata = s1_rdata_q;
    assign busy     = busy_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_qqspi_arbiter.sv
// Bench for qqspi_arbiter: one round-robin instance (a_*) and one fixed-priority instance (b_*) share stimulus,
// each with its own behavioural memory responder.
module tb_qqspi_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s0_valid, s1_valid;
    logic [22:0] s0_addr, s1_addr;
    logic [31:0] s0_wdata, s1_wdata;
    logic [3:0]  s0_wstrb, s1_wstrb;

    logic        a_s0_ready, a_s1_ready, a_m_valid, a_m_ready, a_busy, a_grant;
    logic [31:0] a_s0_rdata, a_s1_rdata, a_m_wdata, a_m_rdata;
    logic [22:0] a_m_addr;
    logic [3:0]  a_m_wstrb;
    logic        b_s0_ready, b_s1_ready, b_m_valid, b_m_ready, b_busy, b_grant;
    logic [31:0] b_s0_rdata, b_s1_rdata, b_m_wdata, b_m_rdata;
    logic [22:0] b_m_addr;
    logic [3:0]  b_m_wstrb;

    int checks = 0;
    int errors = 0;
    int lat    = 20;
    int hold   = 0;

    always #5 clk = ~clk;

    qqspi_arbiter #(.ROUND_ROBIN(1'b1), .PRIO_PORT(1'b1)) u_rr (
        .clk(clk), .resetn(resetn),
        .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s0_ready(a_s0_ready), .s0_rdata(a_s0_rdata),
        .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
        .s1_ready(a_s1_ready), .s1_rdata(a_s1_rdata),
        .m_valid(a_m_valid), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb),
        .m_ready(a_m_ready), .m_rdata(a_m_rdata), .busy(a_busy), .grant(a_grant)
    );

    qqspi_arbiter #(.ROUND_ROBIN(1'b0), .PRIO_PORT(1'b1)) u_fp (
        .clk(clk), .resetn(resetn),
        .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s0_ready(b_s0_ready), .s0_rdata(b_s0_rdata),
        .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
        .s1_ready(b_s1_ready), .s1_rdata(b_s1_rdata),
        .m_valid(b_m_valid), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb),
        .m_ready(b_m_ready), .m_rdata(b_m_rdata), .busy(b_busy), .grant(b_grant)
    );

    // Memory contents seen by the bench: one fixed word, everything else tagged with its address.
    function automatic logic [31:0] tag(input logic [22:0] a);
        return (a == 23'h000123) ? 32'hCAFEBABE : {9'h155, a};
    endfunction

    // Responder: ready after lat cycles of valid, held at least hold extra cycles and until valid drops.
    int a_cnt, a_hold, b_cnt, b_hold;
    always @(posedge clk) begin
        if (!resetn) begin
            a_m_ready <= 1'b0; a_m_rdata <= '0; a_cnt <= 0; a_hold <= 0;
        end else if (a_m_ready) begin
            if (a_hold > 0) a_hold <= a_hold - 1;
            else if (!a_m_valid) a_m_ready <= 1'b0;
        end else if (a_m_valid) begin
            if (a_cnt >= lat - 1) begin
                a_m_ready <= 1'b1; a_m_rdata <= tag(a_m_addr); a_cnt <= 0; a_hold <= hold;
            end else a_cnt <= a_cnt + 1;
        end
    end
    always @(posedge clk) begin
        if (!resetn) begin
            b_m_ready <= 1'b0; b_m_rdata <= '0; b_cnt <= 0; b_hold <= 0;
        end else if (b_m_ready) begin
            if (b_hold > 0) b_hold <= b_hold - 1;
            else if (!b_m_valid) b_m_ready <= 1'b0;
        end else if (b_m_valid) begin
            if (b_cnt >= lat - 1) begin
                b_m_ready <= 1'b1; b_m_rdata <= tag(b_m_addr); b_cnt <= 0; b_hold <= hold;
            end else b_cnt <= b_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Waits for a ready pulse on the selected instance; port = -1 on timeout.
    task automatic wait_pulse(input bit sel_b, output int port, output logic [31:0] rd);
        logic got;
        got  = 1'b0;
        port = -1;
        rd   = '0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (!sel_b && (a_s0_ready || a_s1_ready)) begin
                got = 1'b1;
                chk("pulse_exclusive", {31'd0, a_s0_ready & a_s1_ready}, 32'd0);
                port = a_s1_ready ? 1 : 0;
                rd   = a_s1_ready ? a_s1_rdata : a_s0_rdata;
            end else if (sel_b && (b_s0_ready || b_s1_ready)) begin
                got = 1'b1;
                chk("pulse_exclusive_b", {31'd0, b_s0_ready & b_s1_ready}, 32'd0);
                port = b_s1_ready ? 1 : 0;
                rd   = b_s1_ready ? b_s1_rdata : b_s0_rdata;
            end
        end
        chk("pulse_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge clk);
            idle = !a_busy && !b_busy;
        end
        chk("idle_timeout", {31'd0, idle}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          port, n, exp_port;
        logic        exp_last, bad;
        logic [31:0] rd;

        resetn = 1'b0;
        s0_valid = 1'b1; s0_addr = 23'h000AAA; s0_wdata = '0; s0_wstrb = '0;
        s1_valid = 1'b1; s1_addr = 23'h000BBB; s1_wdata = '0; s1_wstrb = '0;

        // Reset with both requests pending
        repeat (2) @(negedge clk);
        chk("rst_m_valid", {31'd0, a_m_valid}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_s0_ready", {31'd0, a_s0_ready}, 32'd0);
        chk("rst_s1_ready", {31'd0, a_s1_ready}, 32'd0);
        chk("rst_s0_rdata", a_s0_rdata, 32'd0);
        chk("rst_m_addr", {9'd0, a_m_addr}, 32'd0);
        chk("rst_b_m_valid", {31'd0, b_m_valid}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("first_m_valid", {31'd0, a_m_valid}, 32'd1);
        chk("first_grant", {31'd0, a_grant}, 32'd1);
        chk("first_m_addr", {9'd0, a_m_addr}, {9'd0, 23'h000BBB});
        chk("first_b_grant", {31'd0, b_grant}, 32'd1);
        s0_valid = 1'b0;
        wait_pulse(1'b0, port, rd);
        chk("first_port", port, 32'd1);
        chk("first_rdata", rd, tag(23'h000BBB));
        s1_valid = 1'b0;
        wait_idle();

        // Single read on port 0
        s0_addr = 23'h000123; s0_wstrb = 4'b0000; s0_valid = 1'b1;
        @(negedge clk);
        chk("rd_m_valid", {31'd0, a_m_valid}, 32'd1);
        chk("rd_grant", {31'd0, a_grant}, 32'd0);
        chk("rd_m_addr", {9'd0, a_m_addr}, {9'd0, 23'h000123});
        chk("rd_m_wstrb", {28'd0, a_m_wstrb}, 32'd0);
        wait_pulse(1'b0, port, rd);
        chk("rd_port", port, 32'd0);
        chk("rd_rdata", rd, 32'hCAFEBABE);
        chk("rd_s1_quiet", {31'd0, a_s1_ready}, 32'd0);
        s0_valid = 1'b0;
        @(negedge clk);
        chk("rd_pulse_one", {31'd0, a_s0_ready}, 32'd0);
        chk("rd_m_valid_low", {31'd0, a_m_valid}, 32'd0);
        chk("rd_rdata_hold", a_s0_rdata, 32'hCAFEBABE);
        wait_idle();

        // Write on port 1 with ready held for several cycles
        lat = 5; hold = 3;
        s1_addr = 23'h400010; s1_wdata = 32'h11223344; s1_wstrb = 4'b0011; s1_valid = 1'b1;
        @(negedge clk);
        chk("wr_m_addr", {9'd0, a_m_addr}, {9'd0, 23'h400010});
        chk("wr_m_wdata", a_m_wdata, 32'h11223344);
        chk("wr_m_wstrb", {28'd0, a_m_wstrb}, 32'd3);
        chk("wr_grant", {31'd0, a_grant}, 32'd1);
        wait_pulse(1'b0, port, rd);
        chk("wr_port", port, 32'd1);
        s1_valid = 1'b0;
        n = 0; bad = 1'b0;
        while (a_m_ready && n < 50) begin
            n++;
            if (!a_busy || a_m_valid) bad = 1'b1;
            @(negedge clk);
        end
        chk("wr_release_held", {31'd0, bad}, 32'd0);
        chk("wr_ready_len", {31'd0, n >= 3}, 32'd1);
        chk("wr_busy_last", {31'd0, a_busy}, 32'd1);
        @(negedge clk);
        chk("wr_idle", {31'd0, a_busy}, 32'd0);
        hold = 0;
        wait_idle();

        // Round-robin contention from reset
        resetn = 1'b0;
        s0_addr = 23'($urandom); s1_addr = 23'($urandom);
        s0_wstrb = '0; s1_wstrb = '0; s0_valid = 1'b1; s1_valid = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        exp_last = 1'b0;
        for (int k = 0; k < 6; k++) begin
            lat = $urandom_range(1, 6);
            wait_pulse(1'b0, port, rd);
            exp_port = exp_last ? 0 : 1;
            chk("rr_port", port, exp_port);
            chk("rr_grant", {31'd0, a_grant}, exp_port);
            chk("rr_rdata", rd, tag(exp_port == 1 ? s1_addr : s0_addr));
            exp_last = (exp_port == 1);
            if (exp_port == 1) s1_addr = 23'($urandom);
            else s0_addr = 23'($urandom);
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        wait_idle();

        // Fixed priority: port 1 keeps winning until it stops requesting
        resetn = 1'b0;
        s0_addr = 23'($urandom); s1_addr = 23'($urandom); s1_wdata = $urandom;
        s0_valid = 1'b1; s1_valid = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("fp_m_wdata", b_m_wdata, s1_wdata);
        chk("fp_m_wstrb", {28'd0, b_m_wstrb}, {28'd0, s1_wstrb});
        for (int k = 0; k < 4; k++) begin
            lat = $urandom_range(1, 6);
            wait_pulse(1'b1, port, rd);
            chk("fp_port", port, 32'd1);
            chk("fp_rdata", rd, tag(s1_addr));
            s1_addr = 23'($urandom);
        end
        s1_valid = 1'b0;
        wait_pulse(1'b1, port, rd);
        chk("fp_port0", port, 32'd0);
        chk("fp_rdata0", rd, tag(s0_addr));
        s0_valid = 1'b0;
        wait_idle();

        // Reset in the middle of ISSUE
        lat = 20;
        s0_addr = 23'($urandom); s0_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_m_valid", {31'd0, a_m_valid}, 32'd1);
        resetn = 1'b0; s0_valid = 1'b0;
        @(negedge clk);
        chk("mid_m_valid_low", {31'd0, a_m_valid}, 32'd0);
        chk("mid_busy", {31'd0, a_busy}, 32'd0);
        resetn = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (a_s0_ready || a_s1_ready || a_m_valid) bad = 1'b1;
        end
        chk("mid_no_pulse", {31'd0, bad}, 32'd0);
        lat = 4;
        s1_addr = 23'($urandom); s1_valid = 1'b1;
        wait_pulse(1'b0, port, rd);
        chk("mid_after_port", port, 32'd1);
        chk("mid_after_rdata", rd, tag(s1_addr));
        s1_valid = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
